// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// =============================================================================
// apb_rr_arbiter : round-robin sharing of one APB master between NUM_REQ agents
// Revision 1.0
// =============================================================================
module apb_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          slverr,
  output logic                          transfer,
  output logic [ADDR_WIDTH-1:0]         transfer_addr,
  output logic [DATA_WIDTH-1:0]         transfer_wdata,
  output logic                          transfer_write,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pready,
  input  logic                          pslverr,
  input  logic [DATA_WIDTH-1:0]         prdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_last;
  logic [IDX_W-1:0]        r_win;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      r_done;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_slverr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_write;
  logic [IDX_W-1:0]        w_win;
  logic                    w_any;
  logic                    w_xfer_done;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan downward in distance so the closest requester after r_last is the final hit.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[rr_idx(r_last, k)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_last, k);
      end
    end
  end

  assign w_xfer_done = (r_state == S_WAIT) && psel && penable && pready;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    transfer    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        transfer    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (w_xfer_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer fields are frozen at grant time; later requester input changes are ignored.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_addr  <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_write <= req_write[w_win];
            r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          end
        end
        S_WAIT: begin
          if (w_xfer_done) begin
            r_rdata  <= prdata;
            r_slverr <= pslverr;
            r_done   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
            r_last   <= r_win;
            r_gnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt            = r_gnt;
  assign done           = r_done;
  assign rdata          = r_rdata;
  assign slverr         = r_slverr;
  assign transfer_addr  = r_addr;
  assign transfer_wdata = r_wdata;
  assign transfer_write = r_write;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// Bench for apb_rr_arbiter: directed requests, APB slave model, queue-based scoreboard.
module tb_apb_rr_arbiter;
  localparam int N = 4;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    req_write = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [31:0]     rdata;
  logic            slverr;
  logic            transfer;
  logic [31:0]     transfer_addr;
  logic [31:0]     transfer_wdata;
  logic            transfer_write;
  logic            psel = 1'b0;
  logic            penable = 1'b0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;
  logic [31:0]     prdata = '0;

  apb_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .gnt(gnt), .done(done),
    .rdata(rdata), .slverr(slverr), .transfer(transfer),
    .transfer_addr(transfer_addr), .transfer_wdata(transfer_wdata),
    .transfer_write(transfer_write), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Per-requester stimulus and slave response tables
  logic [31:0] a  [N] = '{32'h10, 32'h14, 32'h20, 32'h30};
  logic [31:0] wd [N] = '{32'hDEADBEEF, 32'h22222222, 32'h33333333, 32'h44444444};
  logic        wr [N] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] rd [N] = '{32'h000000A5, 32'h11112222, 32'hCAFE0001, 32'h44440004};
  logic        er [N] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          ws [N] = '{0, 0, 0, 0};
  int          pend [N] = '{0, 0, 0, 0};

  typedef struct { logic [N-1:0] gnt; logic [31:0] addr; logic [31:0] wdata; logic wr; int c; } iss_t;
  typedef struct { logic [N-1:0] done; logic [31:0] rdata; logic err; int c; } dn_t;
  iss_t iq[$];
  dn_t  dq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave/bus model state
  int   m_st = 0;
  int   m_ws = 0;
  int   m_i  = -1;
  logic spur = 1'b0;

  function automatic int idx_of(input logic [31:0] addr);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (a[i] == addr) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
    if (!presetn) begin
      m_st = 0; psel = 0; penable = 0; pready = 0; pslverr = 0; prdata = '0;
    end else begin
      case (m_st)
        0: begin
          psel = spur; penable = spur; pready = spur; pslverr = 0; prdata = '0;
          if (transfer) begin m_i = idx_of(transfer_addr); m_st = 1; end
        end
        1: begin
          psel = 1; penable = 0; pready = 0;
          m_ws = (m_i >= 0) ? ws[m_i] : 0;
          m_st = 2;
        end
        default: begin
          psel = 1; penable = 1;
          if (m_ws == 0) begin
            pready  = 1;
            prdata  = (m_i >= 0) ? rd[m_i] : 32'hBAD0BAD0;
            pslverr = (m_i >= 0) ? er[m_i] : 1'b1;
            m_st    = 0;
          end else begin
            pready = 0; m_ws--;
          end
        end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (done[i] && pend[i] > 0) pend[i]--;
      req[i] = (pend[i] != 0);
    end
  endtask

  task automatic issue(input int i, input int n);
    pend[i] = n;
    req[i]  = 1'b1;
  endtask

  task automatic exp_issue(input int i, input int c);
    iq.push_back('{N'(1) << i, a[i], wd[i], wr[i], c});
  endtask

  task automatic exp_done(input int i, input int c, input logic e);
    dq.push_back('{N'(1) << i, rd[i], e, c});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 400) begin step(); n++; end
    if (n >= 400) begin
      $display("FAIL drain_timeout: queued %0d expected 0", iq.size() + dq.size());
      $fatal(1, "bench stalled");
    end
    step(); step();
  endtask

  // Monitor: reset values at mid-cycle, scoreboard pops on transfer/done.
  initial begin
    iss_t ei;
    dn_t  ed;
    int   stall;
    stall = 0;
    forever begin
      @(negedge pclk);
      #1;
      if (!presetn)
        chk("reset_outputs", 128'({gnt, done, rdata, slverr, transfer, transfer_addr,
                                   transfer_wdata, transfer_write}), 128'd0);
      @(posedge pclk);
      #1;
      if (presetn) begin
        if (transfer) begin
          stall = 0;
          if (iq.size() == 0) chk("transfer_expected", 128'(transfer), 128'd0);
          else begin
            ei = iq.pop_front();
            chk("issue_gnt",   128'(gnt),            128'(ei.gnt));
            chk("issue_addr",  128'(transfer_addr),  128'(ei.addr));
            chk("issue_wdata", 128'(transfer_wdata), 128'(ei.wdata));
            chk("issue_write", 128'(transfer_write), 128'(ei.wr));
            chk("issue_cycle", 128'(cyc),            128'(ei.c));
          end
        end
        if (done != '0) begin
          stall = 0;
          if (dq.size() == 0) chk("done_expected", 128'(done), 128'd0);
          else begin
            ed = dq.pop_front();
            chk("done_vec",    128'(done),   128'(ed.done));
            chk("done_rdata",  128'(rdata),  128'(ed.rdata));
            chk("done_slverr", 128'(slverr), 128'(ed.err));
            chk("done_cycle",  128'(cyc),    128'(ed.c));
            chk("gnt_at_done", 128'(gnt),    128'd0);
          end
        end
        if (iq.size() + dq.size() != 0) stall++;
        else stall = 0;
        if (stall > 60) begin
          chk("watchdog_pending", 128'(iq.size() + dq.size()), 128'd0);
          iq.delete(); dq.delete(); stall = 0;
        end
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32]  = a[i];
      req_wdata[i*32 +: 32] = wd[i];
      req_write[i]          = wr[i];
    end
    presetn = 1'b0;
    repeat (3) step();
    presetn = 1'b1;
    step();

    // Completion handshake seen in IDLE must not produce a done pulse
    spur = 1'b1; repeat (3) step(); spur = 1'b0; step(); step();

    // Single write, requester 0
    t0 = cyc; issue(0, 1); exp_issue(0, t0 + 1); exp_done(0, t0 + 4, 1'b0); drain();

    // Read with three wait states, requester 2
    ws[2] = 3;
    t0 = cyc; issue(2, 1); exp_issue(2, t0 + 1); exp_done(2, t0 + 7, 1'b0); drain();
    ws[2] = 0;

    // Slave error on requester 1 (last becomes 1)
    er[1] = 1'b1;
    t0 = cyc; issue(1, 1); exp_issue(1, t0 + 1); exp_done(1, t0 + 4, 1'b1); drain();
    er[1] = 1'b0;

    // Rotation after skip: last=1, req=1001 -> 3 then 0; 3's slverr clean again
    t0 = cyc; issue(0, 1); issue(3, 1);
    exp_issue(3, t0 + 1); exp_done(3, t0 + 4, 1'b0);
    exp_issue(0, t0 + 5); exp_done(0, t0 + 8, 1'b0);
    drain();

    // Reset during ACCESS: no completion; afterwards requester 0 beats 3
    ws[0] = 20;
    t0 = cyc; issue(0, 1); exp_issue(0, t0 + 1);
    repeat (3) step();
    @(negedge pclk);
    presetn = 1'b0;
    ws[0] = 0;
    issue(3, 1);
    step(); step();
    presetn = 1'b1;
    t0 = cyc;
    exp_issue(0, t0 + 1); exp_done(0, t0 + 4, 1'b0);
    exp_issue(3, t0 + 5); exp_done(3, t0 + 8, 1'b0);
    drain();

    // Full contention: grants rotate 0,1,2,3,0
    t0 = cyc; issue(0, 2); issue(1, 1); issue(2, 1); issue(3, 1);
    exp_issue(0, t0 + 1);  exp_done(0, t0 + 4,  1'b0);
    exp_issue(1, t0 + 5);  exp_done(1, t0 + 8,  1'b0);
    exp_issue(2, t0 + 9);  exp_done(2, t0 + 12, 1'b0);
    exp_issue(3, t0 + 13); exp_done(3, t0 + 16, 1'b0);
    exp_issue(0, t0 + 17); exp_done(0, t0 + 20, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin arbiter that shares the single APB master between NUM_REQ on-chip requesters.
- Accepts one outstanding request per requester and drives the master's transfer/transfer_addr/transfer_wdata/transfer_write inputs.
- Monitors the APB bus (psel/penable/pready) to detect completion, then returns prdata/pslverr to the winning requester with a one-cycle done pulse.
- Exactly one APB transfer is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden).

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- req_write  in  NUM_REQ  1=write, 0=read.
- gnt  out  NUM_REQ  one-hot owner of the current transfer.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_WIDTH  captured prdata, valid while done is high.
- slverr  out  1  captured pslverr, valid while done is high.
- transfer  out  1  start strobe to the APB master.
- transfer_addr  out  ADDR_WIDTH  address to the master.
- transfer_wdata  out  DATA_WIDTH  write data to the master.
- transfer_write  out  1  direction to the master.
- psel  in  1  bus monitor.
- penable  in  1  bus monitor.
- pready  in  1  bus monitor.
- pslverr  in  1  bus monitor.
- prdata  in  DATA_WIDTH  bus monitor.

Behaviour:
- Reset: presetn is asynchronous, active-low; clock is pclk. While presetn is low:
  - state=IDLE.
  - gnt=0, done=0, rdata=0, slverr=0.
  - transfer=0, transfer_addr=0, transfer_wdata=0, transfer_write=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
- Requester protocol:
  - Raise req[i] with addr/wdata/write stable; hold all of them until the done[i] pulse.
  - After done, req[i] may stay high to issue a back-to-back request.
- FSM, registered state, three states:
  - IDLE: if any req bit is set, pick the winner by searching from last+1 upward, wrapping modulo NUM_REQ. Latch the winner index and that requester's addr/wdata/write into registers. Set gnt one-hot. Go to ISSUE. If no req bit is set, stay in IDLE with gnt=0.
  - ISSUE: transfer=1 for exactly this one cycle; transfer_* are driven from the latched registers. Go to WAIT unconditionally.
  - WAIT: transfer=0. On a cycle with psel&penable&pready=1:
    - capture prdata into rdata and pslverr into slverr;
    - set done[winner]=1 on the next cycle;
    - set last=winner;
    - clear gnt;
    - go to IDLE.
- done is registered and high for exactly 1 cycle. It coincides with the IDLE cycle in which the next arbitration is evaluated.
- The requester receiving done must still see its own req as high during that cycle. A new request is therefore granted only if req remains asserted, which allows back-to-back transfers.
- rdata and slverr hold their values until the next completion. They are meaningful only while done is high.
- Latency, from req sampled high in IDLE (edge 0):
  - ISSUE cycle 1;
  - master SETUP cycle 2;
  - master ACCESS cycle 3;
  - with pready=1 in cycle 3, done is high in cycle 4.
  - Each wait-state cycle adds 1.
- Simultaneous requests: only one winner per arbitration. Losers stay pending, with no done pulse and no error.
- Fairness: with all requesters active, grants rotate 0,1,2,3,0,...; a continuously requesting agent waits at most NUM_REQ-1 transfers.
- req deasserted mid-transfer (protocol violation): the transfer still completes and done still pulses to the latched winner. No abort.
- A psel&penable&pready pattern seen outside WAIT is ignored.
- Reset asserted mid-transfer: immediate return to reset values. The master resets on the same signal, so no completion is reported.
- Transfer fields are latched in IDLE, so requester input changes after the grant do not affect the issued transfer.

Test Plan:
- Single write: req=4'b0001, addr0=0x10, wdata0=0xDEADBEEF, write=1, pready=1 → transfer high in cycle 1 with transfer_addr=0x10; done=4'b0001 in cycle 4; gnt=4'b0001 in cycles 1-3.
- Read with wait states: req[2]=1, read of 0x20, pready held low for 3 ACCESS cycles then prdata=0xCAFE0001 → done[2] in cycle 7 with rdata=0xCAFE0001, slverr=0.
- Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0; exactly one done bit per transfer; no overlapping transfer pulses.
- Rotation after a skip: last=1, req=4'b1001 → requester 3 wins (not 0); the next winner is 0.
- Slave error: pslverr=1 on the completing cycle for requester 1 → done[1]=1 with slverr=1; the next transfer reports slverr=0.
- Reset mid-WAIT: presetn low during ACCESS → all outputs 0 at once; after release, the pending req[0] is re-arbitrated with requester 0 given first priority.
